twiddle_gen: RTL and testbench
==============================

TWIDDLE_GEN -- requirements
Module: twiddle_gen

Interface
REQ-001 SHALL have parameter WORDSIZE, default 16: width of each real and imaginary twiddle component, two's complement Q1.(WORDSIZE-1).
REQ-002 SHALL have parameter LOG2N, default 5: log2 of the FFT size; N = 2^LOG2N; legal range 2..8.
REQ-003 SHALL have parameter STAGEBITS, default 3: width of stage_num.
REQ-004 SHALL have parameter ROMFILE, default "twiddle.hex": hex image of N/2 entries, each {cos, -sin} of 2*pi*m/N, m = 0..N/2-1, real component in the upper half.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; every register changes only on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port start, input, 1 bit: one-cycle request to generate one stage's twiddle sequence.
REQ-008 SHALL have port stage_num, input, STAGEBITS bits: radix-2 DIT stage index s, sampled when start is accepted.
REQ-009 SHALL have port inverse, input, 1 bit: conjugate mode for IFFT, sampled when start is accepted.
REQ-010 SHALL have port tw_ready, input, 1 bit: consumer accepts the current twiddle.
REQ-011 SHALL have port tw_valid, output, 1 bit: twiddle and tw_addr are valid.
REQ-012 SHALL have port twiddle, output, 2*WORDSIZE bits: {re, im}.
REQ-013 SHALL have port tw_addr, output, LOG2N-1 bits: ROM index m of the current twiddle.
REQ-014 SHALL have port busy, output, 1 bit: high from start acceptance until the last twiddle is accepted.
REQ-015 SHALL have port stage_done, output, 1 bit: one-cycle pulse in the cycle after the last twiddle of a stage is accepted.
REQ-016 SHALL have port err, output, 1 bit: sticky illegal-stage flag, cleared only by rst.

Function
REQ-017 SHALL implement FSM IDLE -> RUN -> DRAIN -> IDLE.
REQ-018 SHALL accept start only in IDLE; start in RUN or DRAIN SHALL be ignored with no side effect.
REQ-019 SHALL treat start with stage_num >= LOG2N in IDLE as illegal: err <= 1, remain in IDLE, no twiddles issued.
REQ-020 SHALL generate, for each legal start, exactly N/2 twiddles with butterfly counter k = 0..N/2-1 in order.
REQ-021 SHALL compute each address as m = (k AND (2^s - 1)) << (LOG2N-1-s), truncated to LOG2N-1 bits.
REQ-022 SHALL read the ROM synchronously with 1-cycle read latency; the output register SHALL follow the ROM, giving first tw_valid 2 cycles after the start-accept edge.
REQ-023 SHALL advance the pipeline only when (!tw_valid || tw_ready); while stalled, the ROM address, ROM data, twiddle, tw_addr and tw_valid SHALL hold unchanged.
REQ-024 SHALL, with back-to-back tw_ready, sustain one twiddle per cycle with no bubbles.
REQ-025 SHALL, when inverse=1, output {re, -im}; -im SHALL saturate, so -(-2^(WORDSIZE-1)) becomes 2^(WORDSIZE-1)-1.
REQ-026 SHALL enter DRAIN after issuing ROM read k = N/2-1, and SHALL return to IDLE and pulse stage_done in the cycle after the final handshake.
REQ-027 SHALL drop busy together with the stage_done pulse; start is accepted in that same cycle.
REQ-028 SHALL never issue a twiddle while tw_valid=0 or assert tw_valid outside a run.

Reset
REQ-029 SHALL, with rst high on an edge, set FSM=IDLE, k=0, tw_valid=0, twiddle=0, tw_addr=0, busy=0, stage_done=0, err=0.
REQ-030 SHALL abandon any run in progress on rst, with no stage_done and no further twiddles; rst SHALL take priority over start in the same cycle.

Verification
REQ-031 SHALL pass: LOG2N=5, start, s=0, tw_ready=1 -> 16 twiddles, all tw_addr=0, twiddle=0x7FFF_0000; stage_done 18 cycles after start.
REQ-032 SHALL pass: s=2 -> tw_addr sequence 0,4,8,12 repeated 4 times; s=4 -> tw_addr 0..15.
REQ-033 SHALL pass: s=3, inverse=1 -> each imaginary part equals the saturated negation of the ROM value; tw_addr=4 gives 0x5A82_5A82.
REQ-034 SHALL pass: random tw_ready toggling -> outputs stable while stalled, and exactly 16 accepted twiddles in the correct order.
REQ-035 SHALL pass: rst asserted at k=7 -> next cycle tw_valid=0, busy=0, no stage_done; a new start then yields a full correct sequence.
REQ-036 SHALL pass: start with s=5 -> err=1, busy=0, no tw_valid; start during busy ignored.

Source files
------------

// File: rtl/twiddle_gen.sv
// twiddle_gen: streams the radix-2 DIT twiddle factors of one FFT stage from a
// synchronous ROM, with valid/ready flow control and optional IFFT conjugation.
module twiddle_gen #(
    parameter int WORDSIZE  = 16,
    parameter int LOG2N     = 5,
    parameter int STAGEBITS = 3,
    parameter     ROMFILE   = "twiddle.hex"
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [STAGEBITS-1:0]  stage_num,
    input  logic                  inverse,
    input  logic                  tw_ready,
    output logic                  tw_valid,
    output logic [2*WORDSIZE-1:0] twiddle,
    output logic [LOG2N-2:0]      tw_addr,
    output logic                  busy,
    output logic                  stage_done,
    output logic                  err
);

    localparam int N    = 1 << LOG2N;
    localparam int HALF = N / 2;
    localparam int KW   = LOG2N - 1;
    localparam int W    = WORDSIZE;

    localparam longint ONE_Q30 = 64'sd1 <<< 30;
    localparam longint PI_Q30  = 64'sd3373259426;
    localparam longint MAXV    = (64'sd1 <<< (W - 1)) - 64'sd1;
    localparam longint MINV    = -(64'sd1 <<< (W - 1));

    localparam logic [W-1:0] IM_MIN = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] IM_MAX = {1'b0, {(W-1){1'b1}}};

    // The table equals the {cos, -sin} image that ROMFILE names; it is built at
    // elaboration so the block carries no external file dependency.
    localparam int unsigned romfile_unused = $bits(ROMFILE);

    function automatic longint taylor(input longint x, input bit want_sin);
        longint term;
        longint sum;
        longint d;
        term = want_sin ? x : ONE_Q30;
        sum  = term;
        for (int n = 1; n < 12; n++) begin
            d    = want_sin ? longint'((2*n) * (2*n + 1)) : longint'((2*n - 1) * (2*n));
            term = (term * x) >>> 30;
            term = (term * x) >>> 30;
            term = -(term / d);
            sum  = sum + term;
        end
        return sum;
    endfunction

    function automatic logic [W-1:0] quant(input longint v, input bit neg);
        longint mag;
        longint q;
        mag = ((v <<< (W - 1)) + (ONE_Q30 >>> 1)) >>> 30;
        q   = neg ? -mag : mag;
        if (q > MAXV) q = MAXV;
        if (q < MINV) q = MINV;
        return W'(q);
    endfunction

    // Angles are folded into [0, pi/4] so the series stays short and accurate.
    function automatic logic [HALF*2*W-1:0] build_rom();
        logic [HALF*2*W-1:0] img;
        int     r;
        bit     cos_neg;
        bit     swap;
        longint x;
        longint c;
        longint s;
        longint t;
        img = '0;
        for (int m = 0; m < HALF; m++) begin
            cos_neg = (4 * m > N);
            r       = cos_neg ? HALF - m : m;
            swap    = (8 * r > N);
            if (swap) r = N / 4 - r;
            x = (2 * PI_Q30 * longint'(r)) / longint'(N);
            c = taylor(x, 1'b0);
            s = taylor(x, 1'b1);
            if (swap) begin
                t = c;
                c = s;
                s = t;
            end
            img[m*2*W +: 2*W] = {quant(c, cos_neg), quant(s, 1'b1)};
        end
        return img;
    endfunction

    localparam logic [HALF*2*W-1:0] ROM_IMAGE = build_rom();

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                state;
    state_t                state_next;
    logic [KW-1:0]         k;
    logic [STAGEBITS-1:0]  stage_q;
    logic                  inv_q;
    logic                  rd_valid;
    logic [2*W-1:0]        rom_data;
    logic [KW-1:0]         rd_addr;
    logic [KW-1:0]         rom_addr;
    logic                  advance;
    logic                  issue;
    logic                  legal_stage;
    logic                  accept;
    logic                  last_hs;
    logic [W-1:0]          im_conj;

    assign advance     = !tw_valid || tw_ready;
    assign legal_stage = 32'(stage_num) < 32'(LOG2N);
    assign accept      = (state == IDLE) && start && legal_stage;
    assign last_hs     = (state == DRAIN) && tw_valid && tw_ready && !rd_valid;

    // Butterfly k maps to m = (k mod 2^s) * 2^(LOG2N-1-s).
    assign rom_addr = KW'((32'(k) & ((32'd1 << stage_q) - 32'd1)) << (32'(KW) - 32'(stage_q)));
    assign im_conj  = (rom_data[W-1:0] == IM_MIN) ? IM_MAX : (~rom_data[W-1:0] + 1'b1);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = RUN;
            RUN:     if (advance && k == KW'(HALF - 1)) state_next = DRAIN;
            DRAIN:   if (last_hs) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state != IDLE);
        issue = (state == RUN) && advance;
    end

    // Two-stage pipeline (ROM read, output register) that moves as one unit.
    always_ff @(posedge clk) begin
        if (rst) begin
            k          <= '0;
            stage_q    <= '0;
            inv_q      <= 1'b0;
            rd_valid   <= 1'b0;
            rom_data   <= '0;
            rd_addr    <= '0;
            tw_valid   <= 1'b0;
            twiddle    <= '0;
            tw_addr    <= '0;
            stage_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            stage_done <= last_hs;
            if (state == IDLE && start && !legal_stage) err <= 1'b1;
            if (accept) begin
                k       <= '0;
                stage_q <= stage_num;
                inv_q   <= inverse;
            end else if (issue) begin
                k <= k + 1'b1;
            end
            if (advance) begin
                rd_valid <= issue;
                if (issue) begin
                    rom_data <= ROM_IMAGE[32'(rom_addr) * (2*W) +: 2*W];
                    rd_addr  <= rom_addr;
                end
                tw_valid <= rd_valid;
                if (rd_valid) begin
                    twiddle <= {rom_data[2*W-1:W], inv_q ? im_conj : rom_data[W-1:0]};
                    tw_addr <= rd_addr;
                end
            end
        end
    end

endmodule

// File: tb/tb_twiddle_gen.sv
// tb_twiddle_gen: scoreboard bench for twiddle_gen, expected twiddles come from
// a trigonometric reference model evaluated with real arithmetic.
module tb_twiddle_gen;

    localparam int WORDSIZE  = 16;
    localparam int LOG2N     = 5;
    localparam int STAGEBITS = 3;
    localparam int N         = 1 << LOG2N;
    localparam int HALF      = N / 2;
    localparam real PI       = 3.14159265358979323846;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic [STAGEBITS-1:0]  stage_num;
    logic                  inverse;
    logic                  tw_ready;
    logic                  tw_valid;
    logic [2*WORDSIZE-1:0] twiddle;
    logic [LOG2N-2:0]      tw_addr;
    logic                  busy;
    logic                  stage_done;
    logic                  err;

    typedef struct packed {
        logic [LOG2N-2:0]      addr;
        logic [2*WORDSIZE-1:0] tw;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cycle = 0;
    int   done_count = 0;
    int   exp_done = 0;
    bit   ready_random = 1'b0;
    bit   conj_check = 1'b0;

    logic                  prev_stall = 1'b0;
    logic [2*WORDSIZE-1:0] prev_tw;
    logic [LOG2N-2:0]      prev_addr;

    twiddle_gen #(
        .WORDSIZE (WORDSIZE),
        .LOG2N    (LOG2N),
        .STAGEBITS(STAGEBITS),
        .ROMFILE  ("twiddle.hex")
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stage_num (stage_num),
        .inverse   (inverse),
        .tw_ready  (tw_ready),
        .tw_valid  (tw_valid),
        .twiddle   (twiddle),
        .tw_addr   (tw_addr),
        .busy      (busy),
        .stage_done(stage_done),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic int quant(input real v);
        real r;
        int  i;
        r = v * 32768.0;
        if (r >= 0.0) i = int'($floor(r + 0.5));
        else          i = -int'($floor(-r + 0.5));
        if (i > 32767)  i = 32767;
        if (i < -32768) i = -32768;
        return i;
    endfunction

    // Reference: m = (k mod 2^s) * 2^(LOG2N-1-s), value = {cos, -sin} of 2*pi*m/N.
    function automatic exp_t model(input int s, input int k, input bit inv);
        exp_t e;
        int   m;
        int   re;
        int   im;
        real  ang;
        m   = (k % (1 << s)) * (1 << (LOG2N - 1 - s));
        ang = 2.0 * PI * real'(m) / real'(N);
        re  = quant($cos(ang));
        im  = quant(-$sin(ang));
        if (inv) im = (im == -32768) ? 32767 : -im;
        e.addr = 4'(m);
        e.tw   = {16'(re), 16'(im)};
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tw_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            tw_ready = ready_random ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: pops the scoreboard on every handshake and checks stall stability.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (prev_stall)
                checkOutput("stall_hold", {tw_valid, tw_addr, twiddle}, {1'b1, prev_addr, prev_tw});
            if (tw_valid && tw_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_twiddle", {tw_addr, twiddle}, '0);
                    if ({tw_addr, twiddle} == '0) begin
                        n_fail++;
                        $display("[TB] FAIL unexpected_twiddle: got valid twiddle expected none");
                    end
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("twiddle_seq", {tw_addr, twiddle}, e);
                end
                if (conj_check && tw_addr == 4'd4)
                    checkOutput("conj_addr4", twiddle, 32'h5A82_5A82);
            end
            if (stage_done) done_count++;
        end
        prev_stall = tw_valid && !tw_ready && !rst;
        prev_tw    = twiddle;
        prev_addr  = tw_addr;
    end

    task automatic applyStimulus(input int s, input bit inv, input bit check_timing, input bit poke);
        int c0;
        int first;
        bit done;
        stage_num = 3'(s);
        inverse   = inv;
        start     = 1'b1;
        for (int i = 0; i < HALF; i++) exp_q.push_back(model(s, i, inv));
        tick();
        start = 1'b0;
        c0    = cycle;
        first = -1;
        done  = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (tw_valid && first < 0) first = cycle - c0;
            if (poke && i == 5) begin
                stage_num = 3'd1;
                inverse   = ~inv;
                start     = 1'b1;
            end
            if (poke && i == 6) start = 1'b0;
            if (stage_done) done = 1'b1;
        end
        checkOutput("stage_done_seen", 64'(done), 64'd1);
        if (done) begin
            exp_done++;
            if (check_timing) begin
                checkOutput("first_valid_latency", 64'(first), 64'd2);
                checkOutput("stage_done_latency", 64'(cycle - c0), 64'd18);
            end
            checkOutput("busy_low_with_done", 64'(busy), 64'd0);
            checkOutput("all_twiddles_accepted", 64'(exp_q.size()), 64'd0);
        end
        exp_q.delete();
        @(negedge clk);
        checkOutput("stage_done_one_cycle", 64'(stage_done), 64'd0);
        tick();
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        stage_num = '0;
        inverse   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_tw_valid",   64'(tw_valid),   64'd0);
        checkOutput("reset_busy",       64'(busy),       64'd0);
        checkOutput("reset_stage_done", 64'(stage_done), 64'd0);
        checkOutput("reset_err",        64'(err),        64'd0);
        checkOutput("reset_twiddle",    64'(twiddle),    64'd0);
        checkOutput("reset_tw_addr",    64'(tw_addr),    64'd0);
        tick();
        rst = 1'b0;
        tick();

        applyStimulus(0, 1'b0, 1'b1, 1'b0);
        applyStimulus(2, 1'b0, 1'b1, 1'b0);
        applyStimulus(4, 1'b0, 1'b1, 1'b0);
        conj_check = 1'b1;
        applyStimulus(3, 1'b1, 1'b1, 1'b0);
        conj_check = 1'b0;

        ready_random = 1'b1;
        for (int r = 0; r < 6; r++)
            applyStimulus(int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        ready_random = 1'b0;

        applyStimulus(4, 1'b0, 1'b0, 1'b1);

        stage_num = 3'd5;
        start     = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        checkOutput("illegal_err",      64'(err),      64'd1);
        checkOutput("illegal_busy",     64'(busy),     64'd0);
        checkOutput("illegal_no_valid", 64'(tw_valid), 64'd0);
        repeat (4) @(negedge clk);
        checkOutput("illegal_stays_idle", 64'(busy), 64'd0);
        tick();
        applyStimulus(1, 1'b0, 1'b1, 1'b0);
        checkOutput("err_sticky", 64'(err), 64'd1);

        stage_num = 3'd4;
        inverse   = 1'b0;
        start     = 1'b1;
        for (int i = 0; i < HALF; i++) exp_q.push_back(model(4, i, 1'b0));
        tick();
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        checkOutput("abort_tw_valid",   64'(tw_valid),   64'd0);
        checkOutput("abort_busy",       64'(busy),       64'd0);
        checkOutput("abort_stage_done", 64'(stage_done), 64'd0);
        checkOutput("abort_err_clear",  64'(err),        64'd0);
        repeat (20) @(negedge clk);
        tick();
        applyStimulus(4, 1'b1, 1'b1, 1'b0);
        checkOutput("stage_done_count", 64'(done_count), 64'(exp_done));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
